// File: rtl/keyboard_handshake_ctrl_pkg.sv
// Shared types and constants for the keyboard handshake controller:
// key FSM encoding, bus drive levels and FIFO geometry.
package keyboard_handshake_ctrl_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE     = 2'd0,
    KEY_DEBOUNCE = 2'd1,
    KEY_HELD     = 2'd2,
    KEY_RELEASE  = 2'd3
  } key_state_t;

  localparam logic [7:0] High_Impedance = 8'bzzzz_zzzz;
  localparam logic [7:0] Zero_State     = 8'h00;

  localparam int FIFO_DEPTH_C = 4;
  localparam int PTR_W        = 2;
  localparam int CNT_W        = 3;

endpackage

// File: rtl/keyboard_handshake_ctrl_if.sv
// Keyboard-side and CPU-side handshake bundle; the controller uses the slave
// view, the encoder/CPU environment uses the master view.
interface keyboard_handshake_ctrl_if;
  import keyboard_handshake_ctrl_pkg::*;

  logic [7:0]       key_code;
  logic             key_strobe;
  logic             acknowedge;
  logic             Ei1;
  logic [7:0]       WBUS;
  logic             ready;
  logic             overrun;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output key_code, key_strobe, acknowedge, Ei1,
    input  WBUS, ready, overrun, fifo_count
  );

  modport slave (
    input  key_code, key_strobe, acknowedge, Ei1,
    output WBUS, ready, overrun, fifo_count
  );

endinterface

// File: rtl/keyboard_handshake_ctrl_key_fifo.sv
// Four-entry key code FIFO. A pop is honoured only when non-empty, and a push
// into a full FIFO is accepted only when a pop frees the head on the same edge.
module key_fifo
  import keyboard_handshake_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_C
) (
  input  logic             CLK,
  input  logic             nCLR,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       mem_r [FIFO_DEPTH_C];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty = (count_r == 3'd0);
  assign full  = (count_r == FULL_CNT);
  assign count = count_r;
  assign dout  = mem_r[rd_ptr_r];

  // Qualify requests against occupancy
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Storage, wrapping pointers and occupancy count
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      for (int i = 0; i < FIFO_DEPTH_C; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + 2'd1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/keyboard_handshake_ctrl.sv
// Keyboard handshake controller: debounces the encoder strobe, queues one code
// per press, and presents the queue head to the CPU on a tri-state bus.
module keyboard_handshake_ctrl
  import keyboard_handshake_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_C
) (
  input  logic                       CLK,
  input  logic                       nCLR,
  keyboard_handshake_ctrl_if.slave   bus
);

  localparam logic [3:0] DEB_LIM = 4'(DEBOUNCE_CYCLES);

  key_state_t       state_r;
  logic [3:0]       deb_cnt_r;
  logic [3:0]       rel_cnt_r;
  logic             ready_r;
  logic             overrun_r;
  logic             push_s;
  logic             ready_nxt_s;
  logic             drop_s;
  logic [7:0]       head_s;
  logic [CNT_W-1:0] count_s;
  logic             full_s;
  logic             empty_s;

  key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .nCLR  (nCLR),
    .push  (push_s),
    .pop   (bus.acknowedge),
    .din   (bus.key_code),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // A push fires on the edge that completes the debounce window
  always_comb begin
    push_s = 1'b0;
    case (state_r)
      KEY_IDLE:     push_s = bus.key_strobe && (DEB_LIM == 4'd1);
      KEY_DEBOUNCE: push_s = bus.key_strobe && ((deb_cnt_r + 4'd1) == DEB_LIM);
      default:      push_s = 1'b0;
    endcase
  end

  // Next-state view of the queue for the registered flags
  always_comb begin
    drop_s      = push_s && full_s && !bus.acknowedge;
    ready_nxt_s = push_s || !(empty_s || ((count_s == 3'd1) && bus.acknowedge));
  end

  // Key press/release debounce FSM
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state_r   <= KEY_IDLE;
      deb_cnt_r <= 4'd0;
      rel_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        KEY_IDLE: begin
          if (bus.key_strobe) begin
            if (DEB_LIM == 4'd1) begin
              state_r   <= KEY_HELD;
              deb_cnt_r <= 4'd0;
            end else begin
              state_r   <= KEY_DEBOUNCE;
              deb_cnt_r <= 4'd1;
            end
          end
        end
        KEY_DEBOUNCE: begin
          if (!bus.key_strobe) begin
            state_r   <= KEY_IDLE;
            deb_cnt_r <= 4'd0;
          end else if ((deb_cnt_r + 4'd1) == DEB_LIM) begin
            state_r   <= KEY_HELD;
            deb_cnt_r <= 4'd0;
          end else begin
            deb_cnt_r <= deb_cnt_r + 4'd1;
          end
        end
        KEY_HELD: begin
          // A held key never repeats; only a low level leaves this state
          if (!bus.key_strobe) begin
            if (DEB_LIM == 4'd1) begin
              state_r   <= KEY_IDLE;
            end else begin
              state_r   <= KEY_RELEASE;
              rel_cnt_r <= 4'd1;
            end
          end
        end
        KEY_RELEASE: begin
          if (bus.key_strobe) begin
            state_r   <= KEY_HELD;
            rel_cnt_r <= 4'd0;
          end else if ((rel_cnt_r + 4'd1) == DEB_LIM) begin
            state_r   <= KEY_IDLE;
            rel_cnt_r <= 4'd0;
          end else begin
            rel_cnt_r <= rel_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r   <= KEY_IDLE;
          deb_cnt_r <= 4'd0;
          rel_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // Data-valid and sticky overrun flags
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      ready_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      ready_r   <= ready_nxt_s;
      overrun_r <= overrun_r || drop_s;
    end
  end

  assign bus.ready      = ready_r;
  assign bus.overrun    = overrun_r;
  assign bus.fifo_count = count_s;
  assign bus.WBUS       = bus.Ei1 ? (empty_s ? Zero_State : head_s) : High_Impedance;

endmodule

// File: tb/tb_keyboard_handshake_ctrl.sv
// Directed bench for keyboard_handshake_ctrl with hand-computed expectations.
module tb_keyboard_handshake_ctrl;

  logic CLK;
  logic nCLR;
  int   checks_run;
  int   checks_failed;

  keyboard_handshake_ctrl_if kb_if ();

  keyboard_handshake_ctrl #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .CLK  (CLK),
    .nCLR (nCLR),
    .bus  (kb_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_run++;
    if (actual !== expected) begin
      checks_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic press(input logic [7:0] code);
    kb_if.key_code   = code;
    kb_if.key_strobe = 1'b1;
    tick(4);
    kb_if.key_strobe = 1'b0;
    tick(4);
  endtask

  task automatic ack_pulse();
    kb_if.acknowedge = 1'b1;
    tick(1);
    kb_if.acknowedge = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge CLK);
    #1;
    nCLR = 1'b0;
    tick(2);
    nCLR = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_code;
    checks_run       = 0;
    checks_failed    = 0;
    nCLR             = 1'b0;
    kb_if.key_code   = 8'h00;
    kb_if.key_strobe = 1'b0;
    kb_if.acknowedge = 1'b0;
    kb_if.Ei1        = 1'b1;
    tick(2);
    check_value("rst_ready", 32'(kb_if.ready), 32'd0);
    check_value("rst_count", 32'(kb_if.fifo_count), 32'd0);
    check_value("rst_overrun", 32'(kb_if.overrun), 32'd0);
    check_value("rst_wbus", 32'(kb_if.WBUS), 32'h00);
    nCLR = 1'b1;

    // Single debounced press of 0xAC
    kb_if.key_code   = 8'hAC;
    kb_if.key_strobe = 1'b1;
    tick(3);
    check_value("ac_ready_3edges", 32'(kb_if.ready), 32'd0);
    tick(1);
    check_value("ac_ready_4edges", 32'(kb_if.ready), 32'd1);
    check_value("ac_wbus", 32'(kb_if.WBUS), 32'hAC);
    check_value("ac_count", 32'(kb_if.fifo_count), 32'd1);
    tick(6);
    check_value("ac_no_repeat", 32'(kb_if.fifo_count), 32'd1);
    kb_if.key_strobe = 1'b0;
    tick(4);
    ack_pulse();
    check_value("ac_pop_ready", 32'(kb_if.ready), 32'd0);
    check_value("ac_pop_wbus", 32'(kb_if.WBUS), 32'h00);

    // Bouncing press: 3 high, low, 3 high never completes a debounce
    kb_if.key_code   = 8'h5A;
    kb_if.key_strobe = 1'b1;
    tick(3);
    kb_if.key_strobe = 1'b0;
    tick(1);
    kb_if.key_strobe = 1'b1;
    tick(3);
    kb_if.key_strobe = 1'b0;
    check_value("bounce_ready", 32'(kb_if.ready), 32'd0);
    check_value("bounce_count", 32'(kb_if.fifo_count), 32'd0);
    tick(4);

    // Five presses without acknowledge overflow the FIFO; Ei1 low meanwhile
    kb_if.Ei1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      press(8'(k));
    end
    kb_if.Ei1 = 1'b1;
    tick(1);
    check_value("ovf_count", 32'(kb_if.fifo_count), 32'd4);
    check_value("ovf_overrun", 32'(kb_if.overrun), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      exp_code = 8'(k);
      check_value($sformatf("ovf_read%0d", k), 32'(kb_if.WBUS), 32'(exp_code));
      ack_pulse();
    end
    check_value("ovf_drained_ready", 32'(kb_if.ready), 32'd0);
    check_value("ovf_drained_wbus", 32'(kb_if.WBUS), 32'h00);
    ack_pulse();
    check_value("ack_empty_count", 32'(kb_if.fifo_count), 32'd0);
    check_value("overrun_sticky", 32'(kb_if.overrun), 32'd1);

    // Full FIFO with push and pop on the same edge
    apply_reset();
    check_value("rst2_overrun", 32'(kb_if.overrun), 32'd0);
    for (int k = 0; k < 4; k++) begin
      press(8'(8'h11 + k));
    end
    check_value("full_count", 32'(kb_if.fifo_count), 32'd4);
    kb_if.key_code   = 8'h15;
    kb_if.key_strobe = 1'b1;
    tick(3);
    kb_if.acknowedge = 1'b1;
    tick(1);
    kb_if.acknowedge = 1'b0;
    check_value("pp_count", 32'(kb_if.fifo_count), 32'd4);
    check_value("pp_overrun", 32'(kb_if.overrun), 32'd0);
    check_value("pp_head", 32'(kb_if.WBUS), 32'h12);
    kb_if.key_strobe = 1'b0;
    tick(4);
    for (int k = 0; k < 4; k++) begin
      exp_code = 8'(8'h12 + k);
      check_value($sformatf("pp_read%0d", k), 32'(kb_if.WBUS), 32'(exp_code));
      ack_pulse();
    end
    check_value("pp_empty", 32'(kb_if.fifo_count), 32'd0);

    // Release bounce: held, low, high, low, low, high, then clean release
    kb_if.key_code   = 8'h38;
    kb_if.key_strobe = 1'b1;
    tick(4);
    kb_if.key_strobe = 1'b0;
    tick(1);
    kb_if.key_strobe = 1'b1;
    tick(1);
    kb_if.key_strobe = 1'b0;
    tick(2);
    kb_if.key_strobe = 1'b1;
    tick(1);
    kb_if.key_strobe = 1'b0;
    tick(4);
    check_value("relbounce_count", 32'(kb_if.fifo_count), 32'd1);
    check_value("relbounce_wbus", 32'(kb_if.WBUS), 32'h38);
    ack_pulse();

    // Reset with two codes queued and a key held, then fresh debounce
    press(8'hA1);
    kb_if.key_code   = 8'hB2;
    kb_if.key_strobe = 1'b1;
    tick(5);
    check_value("pre_rst_count", 32'(kb_if.fifo_count), 32'd2);
    nCLR = 1'b0;
    #1;
    check_value("async_rst_count", 32'(kb_if.fifo_count), 32'd0);
    check_value("async_rst_ready", 32'(kb_if.ready), 32'd0);
    check_value("async_rst_wbus", 32'(kb_if.WBUS), 32'h00);
    tick(2);
    kb_if.key_code = 8'hC3;
    nCLR = 1'b1;
    tick(3);
    check_value("post_rst_3edges", 32'(kb_if.fifo_count), 32'd0);
    tick(1);
    check_value("post_rst_4edges", 32'(kb_if.fifo_count), 32'd1);
    check_value("post_rst_wbus", 32'(kb_if.WBUS), 32'hC3);
    check_value("post_rst_ready", 32'(kb_if.ready), 32'd1);
    kb_if.key_strobe = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_run, checks_failed);
    $finish;
  end

endmodule
